// File: rtl/scr1_dmem_router_if.sv
// Memory-bus types and the request/response bundle shared by the core side and
// the three downstream targets of the data-memory router.
package scr1_dmem_router_pkg;
   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_IDLE = 2'b00,
      SCR1_MEM_RESP_RDY  = 2'b01,
      SCR1_MEM_RESP_ER   = 2'b10
   } type_scr1_mem_resp_e;
endpackage

interface scr1_dmem_router_if;
   import scr1_dmem_router_pkg::*;

   logic                 req;
   type_scr1_mem_cmd_e   cmd;
   type_scr1_mem_width_e width;
   logic [31:0]          addr;
   logic [31:0]          wdata;
   logic                 req_ack;
   logic [31:0]          rdata;
   type_scr1_mem_resp_e  resp;

   modport master (
      output req, cmd, width, addr, wdata,
      input  req_ack, rdata, resp
   );

   modport slave (
      input  req, cmd, width, addr, wdata,
      output req_ack, rdata, resp
   );
endinterface

// File: rtl/scr1_dmem_router.sv
// Data-memory router: decodes each core request to TCM, timer or the external
// port, keeps one transaction outstanding and returns responses in order.
module scr1_dmem_router
   import scr1_dmem_router_pkg::*;
#(
   parameter logic [31:0] SCR1_TCM_ADDR_MASK      = 32'hFFFF0000,
   parameter logic [31:0] SCR1_TCM_ADDR_PATTERN   = 32'h00480000,
   parameter logic [31:0] SCR1_TIMER_ADDR_MASK    = 32'hFFFFFFE0,
   parameter logic [31:0] SCR1_TIMER_ADDR_PATTERN = 32'h00490000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   scr1_dmem_router_if.slave    dmem,
   scr1_dmem_router_if.master   tcm,
   scr1_dmem_router_if.master   timer,
   scr1_dmem_router_if.master   port
);

   typedef enum logic {ST_ADDR, ST_DATA} state_e;
   typedef enum logic [1:0] {SEL_TCM, SEL_TIMER, SEL_PORT} sel_e;

   state_e              r_state, w_state_nxt;
   sel_e                r_port_sel, w_sel_nxt, w_sel;
   logic                w_sel_ack;
   logic                w_can_issue;
   logic                w_accept;
   type_scr1_mem_resp_e w_tgt_resp;
   logic [31:0]         w_tgt_rdata;

   assign tcm.cmd     = dmem.cmd;
   assign tcm.width   = dmem.width;
   assign tcm.addr    = dmem.addr;
   assign tcm.wdata   = dmem.wdata;
   assign timer.cmd   = dmem.cmd;
   assign timer.width = dmem.width;
   assign timer.addr  = dmem.addr;
   assign timer.wdata = dmem.wdata;
   assign port.cmd    = dmem.cmd;
   assign port.width  = dmem.width;
   assign port.addr   = dmem.addr;
   assign port.wdata  = dmem.wdata;

   always_comb begin
      if ((dmem.addr & SCR1_TCM_ADDR_MASK) == SCR1_TCM_ADDR_PATTERN) begin
         w_sel = SEL_TCM;
      end else if ((dmem.addr & SCR1_TIMER_ADDR_MASK) == SCR1_TIMER_ADDR_PATTERN) begin
         w_sel = SEL_TIMER;
      end else begin
         w_sel = SEL_PORT;
      end
      case (w_sel)
         SEL_TCM:   w_sel_ack = tcm.req_ack;
         SEL_TIMER: w_sel_ack = timer.req_ack;
         default:   w_sel_ack = port.req_ack;
      endcase
   end

   always_comb begin
      case (r_port_sel)
         SEL_TCM: begin
            w_tgt_resp  = tcm.resp;
            w_tgt_rdata = tcm.rdata;
         end
         SEL_TIMER: begin
            w_tgt_resp  = timer.resp;
            w_tgt_rdata = timer.rdata;
         end
         default: begin
            w_tgt_resp  = port.resp;
            w_tgt_rdata = port.rdata;
         end
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_port_sel;
      w_can_issue = 1'b0;
      dmem.resp   = SCR1_MEM_RESP_IDLE;
      dmem.rdata  = '0;
      case (r_state)
         ST_ADDR: w_can_issue = 1'b1;
         ST_DATA: begin
            case (w_tgt_resp)
               SCR1_MEM_RESP_RDY: begin
                  dmem.resp   = SCR1_MEM_RESP_RDY;
                  dmem.rdata  = w_tgt_rdata;
                  w_can_issue = 1'b1;
                  w_state_nxt = ST_ADDR;
               end
               SCR1_MEM_RESP_ER: begin
                  dmem.resp   = SCR1_MEM_RESP_ER;
                  w_state_nxt = ST_ADDR;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
      // Reset gates issue combinationally so target requests drop without a clock
      if (!rst_n) begin
         w_can_issue = 1'b0;
      end
      w_accept     = w_can_issue & dmem.req & w_sel_ack;
      dmem.req_ack = w_can_issue & w_sel_ack;
      tcm.req      = w_can_issue & dmem.req & (w_sel == SEL_TCM);
      timer.req    = w_can_issue & dmem.req & (w_sel == SEL_TIMER);
      port.req     = w_can_issue & dmem.req & (w_sel == SEL_PORT);
      if (w_accept) begin
         w_state_nxt = ST_DATA;
         w_sel_nxt   = w_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_ADDR;
         r_port_sel <= SEL_PORT;
      end else begin
         r_state    <= w_state_nxt;
         r_port_sel <= w_sel_nxt;
      end
   end

endmodule

// File: tb/tb_scr1_dmem_router.sv
// Bench for scr1_dmem_router: directed vector table, reset/stall sequences and
// randomized traffic checked against a queue-based reference model.
module tb_scr1_dmem_router;
   import scr1_dmem_router_pkg::*;

   localparam logic [31:0] TCM_MASK = 32'hFFFF0000;
   localparam logic [31:0] TCM_PAT  = 32'h00480000;
   localparam logic [31:0] TMR_MASK = 32'hFFFFFFE0;
   localparam logic [31:0] TMR_PAT  = 32'h00490000;

   localparam type_scr1_mem_resp_e I = SCR1_MEM_RESP_IDLE;
   localparam type_scr1_mem_resp_e R = SCR1_MEM_RESP_RDY;
   localparam type_scr1_mem_resp_e E = SCR1_MEM_RESP_ER;
   localparam type_scr1_mem_cmd_e  RD = SCR1_MEM_CMD_RD;
   localparam type_scr1_mem_cmd_e  WR = SCR1_MEM_CMD_WR;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   scr1_dmem_router_if dmem_if ();
   scr1_dmem_router_if tcm_if ();
   scr1_dmem_router_if tmr_if ();
   scr1_dmem_router_if prt_if ();

   scr1_dmem_router #(
      .SCR1_TCM_ADDR_MASK      (TCM_MASK),
      .SCR1_TCM_ADDR_PATTERN   (TCM_PAT),
      .SCR1_TIMER_ADDR_MASK    (TMR_MASK),
      .SCR1_TIMER_ADDR_PATTERN (TMR_PAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dmem  (dmem_if),
      .tcm   (tcm_if),
      .timer (tmr_if),
      .port  (prt_if)
   );

   typedef struct {
      logic                req;
      type_scr1_mem_cmd_e  cmd;
      logic [31:0]         addr;
      logic [31:0]         wdata;
      logic [2:0]          ack;     // {tcm, timer, port}
      type_scr1_mem_resp_e rt, rm, rp;
      logic [31:0]         dt, dm, dp;
      logic                eack;
      type_scr1_mem_resp_e eresp;
      logic [31:0]         erdata;
      logic [2:0]          ereq;    // {tcm, timer, port}
   } vec_t;

   int checks = 0;
   int errors = 0;
   int q[$];     // targets with an outstanding transaction, oldest first
   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(
      input logic req, input type_scr1_mem_cmd_e cmd, input logic [31:0] addr,
      input logic [31:0] wdata, input logic [2:0] ack,
      input type_scr1_mem_resp_e rt, input type_scr1_mem_resp_e rm, input type_scr1_mem_resp_e rp,
      input logic [31:0] dt, input logic [31:0] dm, input logic [31:0] dp,
      input logic eack, input type_scr1_mem_resp_e eresp, input logic [31:0] erdata,
      input logic [2:0] ereq);
      vec_t v;
      v.req = req; v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.ack = ack;
      v.rt = rt; v.rm = rm; v.rp = rp; v.dt = dt; v.dm = dm; v.dp = dp;
      v.eack = eack; v.eresp = eresp; v.erdata = erdata; v.ereq = ereq;
      return v;
   endfunction

   task automatic drive_core(input logic req, input type_scr1_mem_cmd_e cmd,
                             input type_scr1_mem_width_e w, input logic [31:0] addr,
                             input logic [31:0] wdata);
      dmem_if.req   = req;
      dmem_if.cmd   = cmd;
      dmem_if.width = w;
      dmem_if.addr  = addr;
      dmem_if.wdata = wdata;
   endtask

   task automatic drive_tgt(input logic [2:0] ack,
                            input type_scr1_mem_resp_e rt, input type_scr1_mem_resp_e rm,
                            input type_scr1_mem_resp_e rp,
                            input logic [31:0] dt, input logic [31:0] dm, input logic [31:0] dp);
      tcm_if.req_ack = ack[2]; tmr_if.req_ack = ack[1]; prt_if.req_ack = ack[0];
      tcm_if.resp = rt; tmr_if.resp = rm; prt_if.resp = rp;
      tcm_if.rdata = dt; tmr_if.rdata = dm; prt_if.rdata = dp;
   endtask

   function automatic int target_of(input logic [31:0] a);
      if ((a & TCM_MASK) == TCM_PAT) return 0;
      if ((a & TMR_MASK) == TMR_PAT) return 1;
      return 2;
   endfunction

   // Inputs must already be driven; checks mid-cycle, then advances one clock.
   task automatic model_step();
      int tgt;
      bit busy, issue, req;
      logic ack_t;
      type_scr1_mem_resp_e rin;
      logic [31:0] din;
      logic [2:0] ereq;
      #3;
      tgt   = target_of(dmem_if.addr);
      busy  = (q.size() != 0);
      rin   = I;
      din   = '0;
      if (busy) begin
         rin = (q[0] == 0) ? tcm_if.resp  : (q[0] == 1) ? tmr_if.resp  : prt_if.resp;
         din = (q[0] == 0) ? tcm_if.rdata : (q[0] == 1) ? tmr_if.rdata : prt_if.rdata;
      end
      issue = !busy || (rin == R);
      ack_t = (tgt == 0) ? tcm_if.req_ack : (tgt == 1) ? tmr_if.req_ack : prt_if.req_ack;
      req   = dmem_if.req;
      ereq  = (issue && req) ? (3'b100 >> tgt) : 3'b000;
      chk("m_ack",   {31'd0, dmem_if.req_ack}, {31'd0, issue & ack_t});
      chk("m_resp",  {30'd0, dmem_if.resp}, {30'd0, busy ? rin : I});
      chk("m_rdata", dmem_if.rdata, (busy && rin == R) ? din : 32'd0);
      chk("m_reqs",  {29'd0, tcm_if.req, tmr_if.req, prt_if.req}, {29'd0, ereq});
      chk("m_bcast", {tmr_if.cmd, tmr_if.width, prt_if.wdata[28:0]},
                     {dmem_if.cmd, dmem_if.width, dmem_if.wdata[28:0]});
      chk("m_addr",  tcm_if.addr, dmem_if.addr);
      @(posedge clk);
      if (busy && rin != I) void'(q.pop_front());
      if (issue && req && ack_t) q.push_back(tgt);
      #1;
   endtask

   function automatic type_scr1_mem_resp_e rnd_resp();
      int r;
      r = $urandom_range(7);
      if (r < 4) return I;
      if (r < 7) return R;
      return E;
   endfunction

   initial begin
      vecs.push_back(mk(1, RD, 32'h00480010, 0, 3'b100, I, I, I, 0, 0, 0, 1, I, 0, 3'b100));
      vecs.push_back(mk(0, RD, 32'h00480010, 0, 3'b000, I, I, I, 0, 0, 0, 0, I, 0, 3'b000));
      vecs.push_back(mk(0, RD, 32'h00480010, 0, 3'b000, R, I, I, 32'hDEADBEEF, 0, 0, 0, R, 32'hDEADBEEF, 3'b000));
      vecs.push_back(mk(1, WR, 32'h00490008, 32'h11112222, 3'b010, I, I, I, 0, 0, 0, 1, I, 0, 3'b010));
      vecs.push_back(mk(1, WR, 32'h80000000, 32'h33334444, 3'b001, I, R, I, 0, 32'h5A5A0000, 0, 1, R, 32'h5A5A0000, 3'b001));
      vecs.push_back(mk(0, WR, 32'h80000000, 0, 3'b000, I, I, R, 0, 0, 0, 0, R, 0, 3'b000));
      vecs.push_back(mk(1, RD, 32'h10000000, 0, 3'b001, I, I, I, 0, 0, 0, 1, I, 0, 3'b001));
      vecs.push_back(mk(1, RD, 32'h10000000, 0, 3'b001, I, I, E, 0, 0, 32'hABCD0123, 0, E, 0, 3'b000));
      vecs.push_back(mk(1, RD, 32'h10000000, 0, 3'b001, I, I, I, 0, 0, 0, 1, I, 0, 3'b001));
      vecs.push_back(mk(0, RD, 32'h10000000, 0, 3'b000, R, I, I, 32'hFFFF0000, 0, 0, 0, I, 0, 3'b000));
      vecs.push_back(mk(1, RD, 32'h00480000, 0, 3'b100, R, I, I, 32'hFFFF0000, 0, 0, 0, I, 0, 3'b000));
      vecs.push_back(mk(0, RD, 32'h00480000, 0, 3'b000, I, I, R, 0, 0, 32'h12345678, 0, R, 32'h12345678, 3'b000));
      vecs.push_back(mk(1, RD, 32'h0049001F, 0, 3'b000, I, I, I, 0, 0, 0, 0, I, 0, 3'b010));
      vecs.push_back(mk(1, RD, 32'h00490020, 0, 3'b000, I, I, I, 0, 0, 0, 0, I, 0, 3'b001));
      vecs.push_back(mk(1, RD, 32'h0048FFFC, 0, 3'b110, R, I, I, 32'h77, 0, 0, 1, I, 0, 3'b100));

      // Reset values, with a live request present
      rst_n = 1'b0;
      drive_core(1'b1, RD, SCR1_MEM_WIDTH_WORD, 32'h00480010, '0);
      drive_tgt(3'b111, I, I, I, '0, '0, '0);
      #3;
      chk("rst_reqs",  {29'd0, tcm_if.req, tmr_if.req, prt_if.req}, 32'd0);
      chk("rst_ack",   {31'd0, dmem_if.req_ack}, 32'd0);
      chk("rst_resp",  {30'd0, dmem_if.resp}, {30'd0, I});
      chk("rst_rdata", dmem_if.rdata, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive_core(vecs[i].req, vecs[i].cmd, SCR1_MEM_WIDTH_WORD, vecs[i].addr, vecs[i].wdata);
         drive_tgt(vecs[i].ack, vecs[i].rt, vecs[i].rm, vecs[i].rp, vecs[i].dt, vecs[i].dm, vecs[i].dp);
         #3;
         chk($sformatf("v%0d_ack", i),   {31'd0, dmem_if.req_ack}, {31'd0, vecs[i].eack});
         chk($sformatf("v%0d_resp", i),  {30'd0, dmem_if.resp}, {30'd0, vecs[i].eresp});
         chk($sformatf("v%0d_rdata", i), dmem_if.rdata, vecs[i].erdata);
         chk($sformatf("v%0d_reqs", i),  {29'd0, tcm_if.req, tmr_if.req, prt_if.req}, {29'd0, vecs[i].ereq});
         @(posedge clk); #1;
      end

      // Reset while a TCM transaction is outstanding and a back-to-back request is live
      drive_core(1'b1, RD, SCR1_MEM_WIDTH_WORD, 32'h00480004, '0);
      drive_tgt(3'b100, R, I, I, 32'h0BADF00D, '0, '0);
      #2;
      chk("pre_rst_resp", {30'd0, dmem_if.resp}, {30'd0, R});
      chk("pre_rst_req",  {29'd0, tcm_if.req, tmr_if.req, prt_if.req}, 32'd4);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_reqs",  {29'd0, tcm_if.req, tmr_if.req, prt_if.req}, 32'd0);
      chk("mid_rst_ack",   {31'd0, dmem_if.req_ack}, 32'd0);
      chk("mid_rst_resp",  {30'd0, dmem_if.resp}, {30'd0, I});
      chk("mid_rst_rdata", dmem_if.rdata, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      q.delete();

      // Fresh request after reset is accepted from the idle state
      drive_tgt(3'b100, I, I, I, '0, '0, '0);
      model_step();
      drive_core(1'b0, RD, SCR1_MEM_WIDTH_WORD, 32'h00480004, '0);
      drive_tgt(3'b000, R, I, I, 32'hCAFE0001, '0, '0);
      model_step();

      // External target stalls acceptance for five cycles
      drive_core(1'b1, RD, SCR1_MEM_WIDTH_HWORD, 32'h80001000, '0);
      drive_tgt(3'b000, I, I, I, '0, '0, '0);
      for (int unsigned c = 0; c < 5; c++) model_step();
      drive_tgt(3'b001, I, I, I, '0, '0, '0);
      model_step();
      drive_core(1'b0, RD, SCR1_MEM_WIDTH_HWORD, 32'h80001000, '0);
      drive_tgt(3'b000, I, I, I, '0, '0, '0);
      model_step();
      drive_tgt(3'b000, I, I, R, '0, '0, 32'h00C0FFEE);
      model_step();

      for (int unsigned n = 0; n < 400; n++) begin
         logic [31:0] a;
         case ($urandom_range(3))
            0:       a = TCM_PAT | ($urandom & 32'h0000FFFF);
            1:       a = TMR_PAT | ($urandom & 32'h0000001F);
            2:       a = TMR_PAT | $urandom_range(32'h0000FFFF, 32'h00000020);
            default: a = $urandom;
         endcase
         drive_core(($urandom_range(3) != 0), type_scr1_mem_cmd_e'($urandom_range(1)),
                    type_scr1_mem_width_e'($urandom_range(2)), a, $urandom);
         drive_tgt(3'($urandom_range(7)), rnd_resp(), rnd_resp(), rnd_resp(),
                   $urandom, $urandom, $urandom);
         model_step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
